// File: rtl/sd_block_reader.sv
// SD card block read data phase: polls for the 0xFE start token, streams the block
// to the sector consumer, then checks the trailing CRC16 (CCITT, MSB first, init 0).
module sd_block_reader #(
  parameter int BLOCK_BYTES   = 512,
  parameter int TOKEN_TIMEOUT = 4096,
  parameter int IDX_W         = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_begin,
  input  logic             abort,
  output logic             poll_req,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic [IDX_W-1:0] data_index,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             err_timeout,
  output logic             err_token
);

  localparam int CNT_W = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TOKEN_TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TOK,
    DATA,
    CRC_HI,
    CRC_LO,
    FINISH
  } state_t;

  state_t           state, state_d;
  logic             pend, pend_d;
  logic             kick, kick_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [15:0]      crc, crc_d;
  logic [7:0]       crc_hi, crc_hi_d;
  logic [7:0]       tok_byte, tok_byte_d;
  logic             poll_req_d;
  logic [7:0]       data_out_d;
  logic             data_valid_d;
  logic [IDX_W-1:0] data_index_d;
  logic             busy_d;
  logic             done_d;
  logic             crc_ok_d;
  logic             err_timeout_d;
  logic             err_token_d;
  logic             rx_take;
  logic [CNT_W-1:0] cnt_inc;

  // One byte of CRC16-CCITT, processed MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ ({16{fb}} & 16'h1021);
    end
    return r;
  endfunction

  // A received byte only counts when it answers our single outstanding poll.
  assign rx_take = rx_valid & pend;
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_d       = state;
    pend_d        = pend;
    kick_d        = kick;
    cnt_d         = cnt;
    idx_d         = idx;
    crc_d         = crc;
    crc_hi_d      = crc_hi;
    tok_byte_d    = tok_byte;
    poll_req_d    = 1'b0;
    data_out_d    = data_out;
    data_valid_d  = 1'b0;
    data_index_d  = data_index;
    busy_d        = busy;
    done_d        = 1'b0;
    crc_ok_d      = crc_ok;
    err_timeout_d = err_timeout;
    err_token_d   = err_token;

    if (state == IDLE) begin
      if (!abort && rd_begin) begin
        state_d       = WAIT_TOK;
        busy_d        = 1'b1;
        kick_d        = 1'b1;
        pend_d        = 1'b0;
        cnt_d         = '0;
        idx_d         = '0;
        crc_d         = 16'h0000;
        data_index_d  = '0;
        crc_ok_d      = 1'b0;
        err_timeout_d = 1'b0;
        err_token_d   = 1'b0;
      end
    end else if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      pend_d  = 1'b0;
      kick_d  = 1'b0;
    end else begin
      unique case (state)
        WAIT_TOK: begin
          if (kick) begin
            poll_req_d = 1'b1;
            pend_d     = 1'b1;
            kick_d     = 1'b0;
          end else if (rx_take) begin
            if (rx_byte == 8'hFE) begin
              state_d    = DATA;
              poll_req_d = 1'b1;
            end else if (rx_byte == 8'hFF) begin
              cnt_d = cnt_inc;
              if (cnt_inc == CNT_LIMIT) begin
                err_timeout_d = 1'b1;
                pend_d        = 1'b0;
                state_d       = FINISH;
              end else begin
                poll_req_d = 1'b1;
              end
            end else begin
              err_token_d = 1'b1;
              tok_byte_d  = rx_byte;
              pend_d      = 1'b0;
              state_d     = FINISH;
            end
          end
        end
        DATA: begin
          if (rx_take) begin
            data_out_d   = rx_byte;
            data_valid_d = 1'b1;
            data_index_d = idx;
            idx_d        = idx + 1'b1;
            crc_d        = crc16_byte(crc, rx_byte);
            poll_req_d   = 1'b1;
            if (idx == IDX_LAST) state_d = CRC_HI;
          end
        end
        CRC_HI: begin
          if (rx_take) begin
            crc_hi_d   = rx_byte;
            poll_req_d = 1'b1;
            state_d    = CRC_LO;
          end
        end
        CRC_LO: begin
          if (rx_take) begin
            crc_ok_d = ({crc_hi, rx_byte} == crc);
            pend_d   = 1'b0;
            state_d  = FINISH;
          end
        end
        FINISH: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          pend_d  = 1'b0;
          kick_d  = 1'b0;
        end
      endcase
    end
  end

  // Registered stage: every output is a flop so reset clears them immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pend        <= 1'b0;
      kick        <= 1'b0;
      cnt         <= '0;
      idx         <= '0;
      crc         <= 16'h0000;
      crc_hi      <= 8'h00;
      tok_byte    <= 8'h00;
      poll_req    <= 1'b0;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      data_index  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      crc_ok      <= 1'b0;
      err_timeout <= 1'b0;
      err_token   <= 1'b0;
    end else begin
      state       <= state_d;
      pend        <= pend_d;
      kick        <= kick_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      crc         <= crc_d;
      crc_hi      <= crc_hi_d;
      tok_byte    <= tok_byte_d;
      poll_req    <= poll_req_d;
      data_out    <= data_out_d;
      data_valid  <= data_valid_d;
      data_index  <= data_index_d;
      busy        <= busy_d;
      done        <= done_d;
      crc_ok      <= crc_ok_d;
      err_timeout <= err_timeout_d;
      err_token   <= err_token_d;
    end
  end

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed bench for sd_block_reader: a card responder answers each poll_req with
// the next scripted byte; outputs are checked with immediate assertions.
module tb_sd_block_reader;
  localparam int BB = 512;
  localparam int TT = 16;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_begin = 1'b0;
  logic          abort = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          poll_req;
  logic [7:0]    data_out;
  logic          data_valid;
  logic [IW-1:0] data_index;
  logic          busy;
  logic          done;
  logic          crc_ok;
  logic          err_timeout;
  logic          err_token;

  sd_block_reader #(.BLOCK_BYTES(BB), .TOKEN_TIMEOUT(TT), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .rd_begin(rd_begin), .abort(abort),
    .poll_req(poll_req), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .data_out(data_out), .data_valid(data_valid), .data_index(data_index),
    .busy(busy), .done(done), .crc_ok(crc_ok),
    .err_timeout(err_timeout), .err_token(err_token)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int npoll = 0;
  int ndv = 0;
  int ndone = 0;
  logic [7:0]    log_d [0:4095];
  logic [IW-1:0] log_i [0:4095];
  logic [7:0]    blk   [0:BB-1];

  always @(negedge clk) begin
    if (poll_req) npoll++;
    if (done) ndone++;
    if (data_valid && ndv < 4096) begin
      log_d[ndv] = data_out;
      log_i[ndv] = data_index;
      ndv++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c0, input logic [7:0] d);
    logic [15:0] c;
    c = c0 ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  function automatic logic [15:0] blk_crc();
    logic [15:0] c;
    c = 16'h0000;
    for (int k = 0; k < BB; k++) c = crc_model(c, blk[k]);
    return c;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start();
    @(posedge clk); #1 rd_begin = 1'b1;
    @(posedge clk); #1 rd_begin = 1'b0;
  endtask

  // Wait for a poll, then answer it one cycle later.
  task automatic serve(input logic [7:0] b, input bit with_begin);
    int n;
    n = 0;
    while (!poll_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!poll_req) begin
      chk("poll_wait", 64'd0, 64'd1);
      return;
    end
    @(posedge clk); #1 rx_byte = b; rx_valid = 1'b1; rd_begin = with_begin;
    @(posedge clk); #1 rx_valid = 1'b0; rd_begin = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk({"done_", tag}, {63'd0, seen}, 64'd1);
  endtask

  task automatic run_block(input int nff, input logic [15:0] crcv, input bit poke_begin);
    start();
    for (int k = 0; k < nff; k++) serve(8'hFF, 1'b0);
    serve(8'hFE, 1'b0);
    for (int k = 0; k < BB; k++) serve(blk[k], poke_begin && (k == 10));
    serve(crcv[15:8], 1'b0);
    serve(crcv[7:0], 1'b0);
  endtask

  task automatic check_log(input int base, input int cnt, input string tag);
    for (int k = 0; k < cnt; k++) begin
      chk({tag, "_data"}, {56'd0, log_d[base+k]}, {56'd0, blk[k]});
      chk({tag, "_index"}, {55'd0, log_i[base+k]}, 64'(k));
    end
  endtask

  initial begin
    int p0, d0, n0;
    logic [15:0] cv;

    // Reset state
    cyc(3);
    chk("reset_outs", {poll_req, data_valid, busy, done, crc_ok, err_timeout, err_token,
                       data_out, data_index}, 64'd0);
    rst = 1'b1;
    cyc(2);

    // Spurious rx_valid in IDLE, then begin with abort in IDLE
    rx_byte = 8'hFE; rx_valid = 1'b1;
    cyc(1); rx_valid = 1'b0;
    cyc(3);
    chk("idle_spurious", {busy, poll_req, data_valid, done}, 64'd0);
    rd_begin = 1'b1; abort = 1'b1;
    cyc(1); rd_begin = 1'b0; abort = 1'b0;
    cyc(3);
    chk("begin_abort_idle", {busy, poll_req}, 64'd0);
    chk("idle_no_polls", 64'(npoll), 64'd0);
    chk("idle_no_data", 64'(ndv), 64'd0);

    // Nominal read: 3 x 0xFF, token, 512 x 0x00, CRC 0x0000
    for (int k = 0; k < BB; k++) blk[k] = 8'h00;
    p0 = npoll; d0 = ndv;
    start();
    chk("busy_after_begin", {busy, poll_req}, 64'b10);
    cyc(1);
    chk("first_poll", {63'd0, poll_req}, 64'd1);
    for (int k = 0; k < 3; k++) serve(8'hFF, 1'b0);
    serve(8'hFE, 1'b0);
    serve(blk[0], 1'b0);
    chk("dv_latency", {63'd0, data_valid}, 64'd1);
    for (int k = 1; k < BB; k++) serve(blk[k], 1'b0);
    serve(8'h00, 1'b0);
    serve(8'h00, 1'b0);
    chk("pre_done", {done, busy}, 64'b01);
    @(negedge clk);
    chk("done_latency", {done, busy}, 64'b10);
    chk("nominal_flags", {crc_ok, err_timeout, err_token}, 64'b100);
    cyc(5);
    chk("nominal_polls", 64'(npoll - p0), 64'd518);
    chk("nominal_dv", 64'(ndv - d0), 64'd512);
    chk("crc_ok_hold", {63'd0, crc_ok}, 64'd1);
    check_log(d0, BB, "nominal");

    // All-0xFF block with correct CRC; begin pulsed while busy
    for (int k = 0; k < BB; k++) blk[k] = 8'hFF;
    d0 = ndv; n0 = ndone;
    run_block(0, 16'h7FA1, 1'b1);
    wait_done("allff");
    chk("allff_crc_ok", {crc_ok, err_timeout, err_token}, 64'b100);
    cyc(3);
    chk("allff_one_done", 64'(ndone - n0), 64'd1);
    chk("allff_dv", 64'(ndv - d0), 64'd512);
    check_log(d0, BB, "allff");

    // All-0xFF block with wrong CRC
    n0 = ndone;
    run_block(0, 16'h7FA0, 1'b0);
    wait_done("allff_bad");
    chk("allff_bad_crc", {crc_ok, err_timeout, err_token}, 64'b000);
    cyc(2);
    chk("allff_bad_done", 64'(ndone - n0), 64'd1);

    // Patterned block, CRC from the bench model
    for (int k = 0; k < BB; k++) blk[k] = 8'((k * 37 + 11) ^ (k >> 3));
    cv = blk_crc();
    d0 = ndv;
    run_block(2, cv, 1'b0);
    wait_done("pattern");
    chk("pattern_crc_ok", {63'd0, crc_ok}, 64'd1);
    cyc(2);
    check_log(d0, BB, "pattern");

    // Token timeout: card answers 0xFF only
    p0 = npoll; d0 = ndv;
    start();
    for (int k = 0; k < TT; k++) serve(8'hFF, 1'b0);
    wait_done("timeout");
    chk("timeout_flags", {crc_ok, err_timeout, err_token}, 64'b010);
    cyc(8);
    chk("timeout_polls", 64'(npoll - p0), 64'(TT));
    chk("timeout_no_dv", 64'(ndv - d0), 64'd0);

    // Error token
    p0 = npoll;
    start();
    serve(8'hFF, 1'b0);
    serve(8'h05, 1'b0);
    wait_done("errtok");
    chk("errtok_flags", {crc_ok, err_timeout, err_token}, 64'b001);
    cyc(8);
    chk("errtok_polls", 64'(npoll - p0), 64'd2);

    // Abort after data byte 100, with an rx_valid in the abort cycle
    for (int k = 0; k < BB; k++) blk[k] = 8'(k ^ 8'hA5);
    p0 = npoll; d0 = ndv; n0 = ndone;
    start();
    serve(8'hFE, 1'b0);
    for (int k = 0; k <= 100; k++) serve(blk[k], 1'b0);
    @(posedge clk); #1 abort = 1'b1; rx_valid = 1'b1; rx_byte = 8'h5A;
    @(posedge clk); #1 abort = 1'b0; rx_valid = 1'b0;
    chk("abort_busy", {busy, data_valid}, 64'd0);
    rx_valid = 1'b1; rx_byte = 8'h77;
    cyc(1); rx_valid = 1'b0;
    cyc(10);
    chk("abort_no_done", 64'(ndone - n0), 64'd0);
    chk("abort_dv", 64'(ndv - d0), 64'd101);
    chk("abort_polls", 64'(npoll - p0), 64'd103);
    chk("abort_flags", {crc_ok, err_timeout, err_token, busy}, 64'd0);
    check_log(d0, 101, "abort");

    // Clean block after abort: index restarts at 0
    cv = blk_crc();
    d0 = ndv;
    run_block(1, cv, 1'b0);
    wait_done("after_abort");
    chk("after_abort_crc", {crc_ok, err_timeout, err_token}, 64'b100);
    cyc(2);
    check_log(d0, BB, "after_abort");

    // Reset asserted during DATA, in a cycle with data_valid high
    start();
    serve(8'hFE, 1'b0);
    for (int k = 0; k < 50; k++) serve(blk[k], 1'b0);
    chk("dv_before_rst", {data_valid, busy}, 64'b11);
    #1 rst = 1'b0;
    #1;
    chk("reset_mid", {poll_req, data_valid, busy, done, crc_ok, err_timeout, err_token,
                      data_out, data_index}, 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    p0 = npoll; d0 = ndv;
    rx_valid = 1'b1; rx_byte = 8'h3C;
    cyc(1); rx_valid = 1'b0;
    cyc(6);
    chk("late_rx_ignored", {busy, poll_req, done}, 64'd0);
    chk("late_rx_no_dv", 64'(ndv - d0), 64'd0);
    chk("late_rx_no_poll", 64'(npoll - p0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
